// File: rtl/brq_tlul_host_arb.sv
// TL-UL host adapter: arbitrates NumCh core request channels onto one
// TL-UL A channel and routes D-channel responses back by source id.
package tlul_pkg;
    parameter int TL_AIW = 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef struct packed {
        logic [4:0] rsvd;
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    parameter tl_a_user_t TL_A_USER_DEFAULT = '0;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [1:0]        a_size;
        logic [TL_AIW-1:0] a_source;
        logic [31:0]       a_address;
        logic [3:0]        a_mask;
        logic [31:0]       a_data;
        tl_a_user_t        a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [1:0]        d_size;
        logic [TL_AIW-1:0] d_source;
        logic              d_sink;
        logic [31:0]       d_data;
        logic [13:0]       d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;
endpackage

module brq_tlul_host_arb
    import tlul_pkg::*;
#(
    parameter int   NumCh     = 2,
    parameter int   MaxReqs   = 2,
    parameter logic FixedPrio = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumCh-1:0]       req_i,
    output logic [NumCh-1:0]       gnt_o,
    input  logic [NumCh-1:0][31:0] addr_i,
    input  logic [NumCh-1:0]       we_i,
    input  logic [NumCh-1:0][31:0] wdata_i,
    input  logic [NumCh-1:0][3:0]  be_i,
    output logic [NumCh-1:0]       valid_o,
    output logic [31:0]            rdata_o,
    output logic                   err_o,
    output tl_h2d_t                tl_h_o,
    input  tl_d2h_t                tl_h_i,
    output logic                   spurious_o
);
    localparam int CW = $clog2(MaxReqs + 1);
    localparam int PW = (NumCh > 1) ? $clog2(NumCh) : 1;

    logic [CW-1:0]    cnt_q [NumCh];
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    lock_ch_q;
    logic             lock_q;
    logic [NumCh-1:0] elig;
    logic [NumCh-1:0] rsp_hit;
    logic [PW-1:0]    win_arb;
    logic [PW-1:0]    win;
    logic             found;
    logic             a_valid;
    logic             accept;
    logic             routed;
    int unsigned      idx;

    always_comb begin
        for (int c = 0; c < NumCh; c++) begin
            elig[c]    = req_i[c] && (cnt_q[c] < CW'(MaxReqs));
            rsp_hit[c] = rst_ni && tl_h_i.d_valid &&
                         (tl_h_i.d_source == TL_AIW'(c)) &&
                         (cnt_q[c] != '0);
        end
    end

    // First eligible channel scanning upward from ptr_q (or from 0).
    always_comb begin
        win_arb = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NumCh; i++) begin
            idx = FixedPrio ? i : (int'(ptr_q) + i) % NumCh;
            if (!found && elig[PW'(idx)]) begin
                found   = 1'b1;
                win_arb = PW'(idx);
            end
        end
    end

    assign win     = lock_q ? lock_ch_q : win_arb;
    assign a_valid = rst_ni && (lock_q || found);
    assign accept  = a_valid && tl_h_i.a_ready;
    assign gnt_o   = accept ? (NumCh'(1) << win) : '0;

    always_comb begin
        tl_h_o           = '0;
        tl_h_o.a_valid   = a_valid;
        tl_h_o.a_opcode  = !we_i[win]           ? Get :
                           (be_i[win] == 4'hF)  ? PutFullData :
                                                  PutPartialData;
        tl_h_o.a_param   = 3'd0;
        tl_h_o.a_size    = 2'd2;
        tl_h_o.a_source  = TL_AIW'(win);
        tl_h_o.a_address = {addr_i[win][31:2], 2'b00};
        tl_h_o.a_mask    = we_i[win] ? be_i[win] : 4'hF;
        tl_h_o.a_data    = wdata_i[win];
        tl_h_o.a_user    = TL_A_USER_DEFAULT;
        tl_h_o.d_ready   = 1'b1;
    end

    assign routed     = |rsp_hit;
    assign valid_o    = rsp_hit;
    assign spurious_o = rst_ni && tl_h_i.d_valid && !routed;
    assign rdata_o    = routed ? tl_h_i.d_data : 32'h0;
    assign err_o      = routed && tl_h_i.d_error;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NumCh; c++) cnt_q[c] <= '0;
            ptr_q     <= '0;
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            for (int c = 0; c < NumCh; c++) begin
                if (gnt_o[c] && !rsp_hit[c])
                    cnt_q[c] <= cnt_q[c] + CW'(1);
                else if (!gnt_o[c] && rsp_hit[c])
                    cnt_q[c] <= cnt_q[c] - CW'(1);
            end
            if (accept) begin
                ptr_q  <= (win == PW'(NumCh - 1)) ? '0 : win + PW'(1);
                lock_q <= 1'b0;
            end else if (a_valid) begin
                lock_q    <= 1'b1;
                lock_ch_q <= win;
            end
        end
    end

    logic unused_in;
    assign unused_in = ^{addr_i, tl_h_i.d_opcode, tl_h_i.d_param,
                         tl_h_i.d_size, tl_h_i.d_sink, tl_h_i.d_user};
endmodule

// File: tb/tb_brq_tlul_host_arb.sv
// Directed bench for brq_tlul_host_arb at NumCh=2, MaxReqs=2, round-robin.
// Inputs change 1 time unit after the rising edge; checks run 2 units later.
module tb_brq_tlul_host_arb;
    import tlul_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [1:0]      req_i;
    logic [1:0]      gnt_o;
    logic [1:0][31:0] addr_i;
    logic [1:0]      we_i;
    logic [1:0][31:0] wdata_i;
    logic [1:0][3:0] be_i;
    logic [1:0]      valid_o;
    logic [31:0]     rdata_o;
    logic            err_o;
    tl_h2d_t         tl_h_o;
    tl_d2h_t         tl_h_i;
    logic            spurious_o;

    int n_vec = 0;
    int n_err = 0;

    brq_tlul_host_arb #(.NumCh(2), .MaxReqs(2), .FixedPrio(1'b0)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .wdata_i    (wdata_i),
        .be_i       (be_i),
        .valid_o    (valid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .tl_h_o     (tl_h_o),
        .tl_h_i     (tl_h_i),
        .spurious_o (spurious_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic rsp(input logic [7:0] src, input logic [31:0] data,
                       input logic err);
        tl_h_i.d_valid  = 1'b1;
        tl_h_i.d_source = src;
        tl_h_i.d_data   = data;
        tl_h_i.d_error  = err;
    endtask

    task automatic drain(input logic [7:0] src);
        rsp(src, 32'h0, 1'b0);
        step();
        tl_h_i.d_valid = 1'b0;
    endtask

    initial begin
        rst_ni  = 1'b0;
        req_i   = '0;
        addr_i  = '0;
        we_i    = '0;
        wdata_i = '0;
        be_i    = '0;
        tl_h_i  = '0;
        tl_h_i.a_ready = 1'b1;

        #2;
        req_i = 2'b11;
        rsp(8'd0, 32'h55, 1'b1);
        #1;
        chk("rst_a_valid", 64'(tl_h_o.a_valid), 64'd0);
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_spurious", 64'(spurious_o), 64'd0);
        chk("rst_rdata", 64'(rdata_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_d_ready", 64'(tl_h_o.d_ready), 64'd1);
        req_i = '0;
        tl_h_i.d_valid = 1'b0;
        step();
        rst_ni = 1'b1;

        // round-robin alternation with both channels requesting
        req_i  = 2'b11;
        addr_i[0] = 32'h0000_0100;
        addr_i[1] = 32'h0000_0204;
        #2;
        chk("rr0_gnt", 64'(gnt_o), 64'h1);
        chk("rr0_src", 64'(tl_h_o.a_source), 64'h0);
        chk("rr0_op", 64'(tl_h_o.a_opcode), 64'(Get));
        chk("rr0_mask", 64'(tl_h_o.a_mask), 64'hF);
        chk("rr0_addr", 64'(tl_h_o.a_address), 64'h100);
        chk("rr0_size", 64'(tl_h_o.a_size), 64'd2);
        step(); #2;
        chk("rr1_gnt", 64'(gnt_o), 64'h2);
        chk("rr1_src", 64'(tl_h_o.a_source), 64'h1);
        chk("rr1_addr", 64'(tl_h_o.a_address), 64'h204);
        step(); #2;
        chk("rr2_gnt", 64'(gnt_o), 64'h1);
        chk("rr2_src", 64'(tl_h_o.a_source), 64'h0);
        step(); #2;
        chk("rr3_gnt", 64'(gnt_o), 64'h2);
        chk("rr3_src", 64'(tl_h_o.a_source), 64'h1);
        step(); #2;
        chk("rr_full_a_valid", 64'(tl_h_o.a_valid), 64'd0);
        chk("rr_full_gnt", 64'(gnt_o), 64'd0);
        req_i = '0;
        rsp(8'd0, 32'hA0, 1'b0);
        #2;
        chk("rsp0_valid", 64'(valid_o), 64'h1);
        chk("rsp0_rdata", 64'(rdata_o), 64'hA0);
        chk("rsp0_err", 64'(err_o), 64'd0);
        step();
        rsp(8'd1, 32'hA1, 1'b1);
        #2;
        chk("rsp1_valid", 64'(valid_o), 64'h2);
        chk("rsp1_rdata", 64'(rdata_o), 64'hA1);
        chk("rsp1_err", 64'(err_o), 64'd1);
        step();
        drain(8'd0);
        drain(8'd1);
        tl_h_i.d_data  = 32'hFFFF_FFFF;
        tl_h_i.d_error = 1'b1;
        #2;
        chk("idle_rdata", 64'(rdata_o), 64'd0);
        chk("idle_err", 64'(err_o), 64'd0);
        tl_h_i.d_data  = 32'h0;
        tl_h_i.d_error = 1'b0;

        // MaxReqs limit on ch0
        req_i = 2'b01;
        #2;
        chk("max_g1", 64'(gnt_o), 64'h1);
        step(); #2;
        chk("max_g2", 64'(gnt_o), 64'h1);
        step(); #2;
        chk("max_stall_valid", 64'(tl_h_o.a_valid), 64'd0);
        chk("max_stall_gnt", 64'(gnt_o), 64'd0);
        step();
        rsp(8'd0, 32'hB0, 1'b0);
        #2;
        chk("max_rsp_valid", 64'(valid_o), 64'h1);
        chk("max_rsp_gnt", 64'(gnt_o), 64'd0);
        step();
        tl_h_i.d_valid = 1'b0;
        #2;
        chk("max_g3", 64'(gnt_o), 64'h1);
        step();
        req_i = '0;
        drain(8'd0);
        drain(8'd0);

        // A-channel lock while a_ready is low
        tl_h_i.a_ready = 1'b0;
        req_i = 2'b01;
        addr_i[0] = 32'h1000_0010;
        addr_i[1] = 32'h3000_0000;
        #2;
        chk("lock0_a_valid", 64'(tl_h_o.a_valid), 64'd1);
        chk("lock0_gnt", 64'(gnt_o), 64'd0);
        chk("lock0_src", 64'(tl_h_o.a_source), 64'h0);
        step();
        req_i = 2'b11;
        #2;
        chk("lock1_src", 64'(tl_h_o.a_source), 64'h0);
        chk("lock1_addr", 64'(tl_h_o.a_address), 64'h1000_0010);
        chk("lock1_gnt", 64'(gnt_o), 64'd0);
        step(); #2;
        chk("lock2_src", 64'(tl_h_o.a_source), 64'h0);
        chk("lock2_addr", 64'(tl_h_o.a_address), 64'h1000_0010);
        step();
        tl_h_i.a_ready = 1'b1;
        #2;
        chk("lock_acc_gnt", 64'(gnt_o), 64'h1);
        chk("lock_acc_src", 64'(tl_h_o.a_source), 64'h0);
        step();
        req_i = 2'b10;
        #2;
        chk("lock_next_gnt", 64'(gnt_o), 64'h2);
        chk("lock_next_src", 64'(tl_h_o.a_source), 64'h1);
        chk("lock_next_addr", 64'(tl_h_o.a_address), 64'h3000_0000);
        step();
        req_i = '0;
        drain(8'd0);
        drain(8'd1);

        // write encodings
        req_i = 2'b10;
        we_i  = 2'b10;
        be_i[1]    = 4'h3;
        addr_i[1]  = 32'h2000_0006;
        wdata_i[1] = 32'hDEAD_BEEF;
        #2;
        chk("pp_gnt", 64'(gnt_o), 64'h2);
        chk("pp_op", 64'(tl_h_o.a_opcode), 64'(PutPartialData));
        chk("pp_addr", 64'(tl_h_o.a_address), 64'h2000_0004);
        chk("pp_mask", 64'(tl_h_o.a_mask), 64'h3);
        chk("pp_data", 64'(tl_h_o.a_data), 64'hDEAD_BEEF);
        chk("pp_src", 64'(tl_h_o.a_source), 64'h1);
        step();
        req_i = 2'b01;
        we_i  = 2'b01;
        be_i[0]    = 4'hF;
        addr_i[0]  = 32'h0000_0040;
        wdata_i[0] = 32'h1234_5678;
        #2;
        chk("pf_op", 64'(tl_h_o.a_opcode), 64'(PutFullData));
        chk("pf_mask", 64'(tl_h_o.a_mask), 64'hF);
        chk("pf_data", 64'(tl_h_o.a_data), 64'h1234_5678);
        step();
        req_i = '0;
        we_i  = '0;
        drain(8'd1);
        drain(8'd0);

        // spurious responses
        rsp(8'd5, 32'h77, 1'b1);
        #2;
        chk("sp5_spurious", 64'(spurious_o), 64'd1);
        chk("sp5_valid", 64'(valid_o), 64'd0);
        chk("sp5_rdata", 64'(rdata_o), 64'd0);
        step();
        rsp(8'd0, 32'h78, 1'b0);
        #2;
        chk("sp0_spurious", 64'(spurious_o), 64'd1);
        chk("sp0_valid", 64'(valid_o), 64'd0);
        step();
        tl_h_i.d_valid = 1'b0;
        #2;
        chk("sp_idle", 64'(spurious_o), 64'd0);
        req_i = 2'b01;
        #2;
        chk("sp_cnt_g1", 64'(gnt_o), 64'h1);
        step(); #2;
        chk("sp_cnt_g2", 64'(gnt_o), 64'h1);
        step(); #2;
        chk("sp_cnt_full", 64'(tl_h_o.a_valid), 64'd0);
        req_i = '0;
        drain(8'd0);
        drain(8'd0);

        // same-cycle accept and response on ch0
        req_i = 2'b01;
        #2;
        chk("sim_pre_gnt", 64'(gnt_o), 64'h1);
        step();
        rsp(8'd0, 32'hC0, 1'b0);
        #2;
        chk("sim_gnt", 64'(gnt_o), 64'h1);
        chk("sim_valid", 64'(valid_o), 64'h1);
        chk("sim_rdata", 64'(rdata_o), 64'hC0);
        step();
        tl_h_i.d_valid = 1'b0;
        #2;
        chk("sim_post_gnt", 64'(gnt_o), 64'h1);
        step(); #2;
        chk("sim_post_full", 64'(tl_h_o.a_valid), 64'd0);

        // reset with two outstanding on ch0
        rst_ni = 1'b0;
        #2;
        chk("mid_rst_a_valid", 64'(tl_h_o.a_valid), 64'd0);
        chk("mid_rst_gnt", 64'(gnt_o), 64'd0);
        req_i = '0;
        step();
        rst_ni = 1'b1;
        rsp(8'd0, 32'hD0, 1'b0);
        #2;
        chk("post_rst_spurious", 64'(spurious_o), 64'd1);
        chk("post_rst_valid", 64'(valid_o), 64'd0);
        step();
        tl_h_i.d_valid = 1'b0;
        req_i = 2'b01;
        #2;
        chk("post_rst_gnt", 64'(gnt_o), 64'h1);
        step();
        req_i = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/brq_tlul_host_arb.md
BRQ_TLUL_HOST_ARB -- requirements
Module: brq_tlul_host_arb

Interface
REQ-001 SHALL have parameter NumCh, default 2: number of core-side request channels, legal range 1..8.
REQ-002 SHALL have parameter MaxReqs, default 2: maximum outstanding transactions per channel, legal range 1..15.
REQ-003 SHALL have parameter FixedPrio, default 1'b0: 0 selects round-robin arbitration; 1 selects fixed priority with the lowest channel index winning.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port req_i, input, NumCh bits: per-channel request, held until granted.
REQ-007 SHALL have port gnt_o, output, NumCh bits: per-channel grant, one-cycle pulse.
REQ-008 SHALL have port addr_i, input, NumCh x 32 bits: per-channel byte address.
REQ-009 SHALL have port we_i, input, NumCh bits: per-channel write enable.
REQ-010 SHALL have port wdata_i, input, NumCh x 32 bits: per-channel write data.
REQ-011 SHALL have port be_i, input, NumCh x 4 bits: per-channel byte enables.
REQ-012 SHALL have port valid_o, output, NumCh bits: per-channel response valid, one-cycle pulse.
REQ-013 SHALL have port rdata_o, output, 32 bits: response data, shared by all channels.
REQ-014 SHALL have port err_o, output, 1 bit: response error, shared by all channels.
REQ-015 SHALL have port tl_h_o, output, tlul_pkg::tl_h2d_t: TL-UL host A-channel request and d_ready.
REQ-016 SHALL have port tl_h_i, input, tlul_pkg::tl_d2h_t: TL-UL D-channel response and a_ready.
REQ-017 SHALL have port spurious_o, output, 1 bit: one-cycle pulse on a dropped response.

Function
REQ-018 SHALL treat a channel as eligible when req_i[c]=1 and cnt[c]<MaxReqs, where cnt[c] is the channel's outstanding count (width clog2(MaxReqs+1)).
REQ-019 SHALL drive a_valid=1 when any channel is eligible or the lock is set.
REQ-020 SHALL select the winner from eligible channels: round-robin starting at ptr_q, or lowest index when FixedPrio=1.
REQ-021 SHALL set the lock when a_valid=1 and a_ready=0, capturing the winner in lock_ch_q; while locked, the A channel carries lock_ch_q regardless of other requests.
REQ-022 SHALL accept a request in the cycle a_valid=1 and a_ready=1, asserting gnt_o[winner] combinationally in that same cycle, clearing the lock and incrementing cnt[winner].
REQ-023 SHALL advance ptr_q to (winner+1) mod NumCh on each acceptance; ptr_q SHALL NOT change otherwise.
REQ-024 SHALL encode the A-channel fields as follows:
- a_opcode = Get when we=0, PutFullData when we=1 and be=4'hF, otherwise PutPartialData.
- a_size=2; a_param=0; a_address={addr[31:2],2'b00}.
- a_mask = be for writes, 4'hF for reads.
- a_source = zero-extended winner index; a_data = wdata; a_user = tlul_pkg default.
REQ-025 SHALL drive d_ready=1 constantly.
REQ-026 SHALL route each response, when d_valid=1, to c=d_source: pulse valid_o[c], drive rdata_o=d_data and err_o=d_error in that same cycle, and decrement cnt[c].
REQ-027 SHALL drop a response whose d_source>=NumCh or whose cnt[c]=0, asserting no valid_o, pulsing spurious_o, and leaving all counters unchanged.
REQ-028 SHALL leave cnt[c] unchanged when an acceptance and a response for the same channel occur in one cycle.
REQ-029 SHALL return responses in order within a channel, because TL-UL orders same-source responses; no reordering storage is required.
REQ-030 SHALL hold rdata_o and err_o at 0 in every cycle with no routed response.

Reset
REQ-031 SHALL, while rst_ni=0, asynchronously clear all of the following: cnt, ptr_q, lock_q, lock_ch_q, gnt_o, valid_o, spurious_o, a_valid, rdata_o and err_o.
REQ-032 SHALL not replay or complete transactions that were outstanding when reset was asserted mid-operation; responses arriving after reset SHALL be dropped per REQ-027.

Verification
REQ-033 SHALL be covered by a directed test: NumCh=2, both req_i=1 continuously, a_ready=1, RR mode -> grants alternate 0,1,0,1 and a_source alternates 0,1.
REQ-034 SHALL be covered by a directed test: MaxReqs=2, ch0 issues 3 reads with no D responses -> two grants, then a_valid=0 and cnt[0]=2; one response for source 0 -> third grant follows.
REQ-035 SHALL be covered by a directed test: a_ready=0 for 3 cycles while ch0 is pending and ch1 rises -> a_source and a_address stay at ch0's values until acceptance, then ch1 is granted.
REQ-036 SHALL be covered by a directed test: ch1 write be=4'h3, addr=32'h2000_0006 -> a_opcode=PutPartialData, a_address=32'h2000_0004, a_mask=4'h3.
REQ-037 SHALL be covered by a directed test: d_valid with d_source=5 at NumCh=2, then with source 0 at cnt[0]=0 -> spurious_o pulses twice, valid_o stays 0, counters unchanged.
REQ-038 SHALL be covered by a directed test: simultaneous acceptance and response on ch0 with cnt[0]=1 -> cnt[0] stays 1, gnt_o[0] and valid_o[0] both pulse.
